// File: rtl/serial_mmio_pkg.sv
// Shared definitions for the memory-mapped serial port: register offsets,
// STATUS/CTRL bit positions and the STATUS word packing helper.
package serial_mmio_pkg;

    localparam logic [3:0] OFF_DATA   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;

    localparam int ST_RX_NONEMPTY  = 0;
    localparam int ST_TX_NOTFULL   = 1;
    localparam int ST_TX_OVERRUN   = 2;
    localparam int ST_RX_COUNT_LSB = 8;
    localparam int ST_TX_COUNT_LSB = 16;

    localparam int CTRL_RX_IRQ_EN = 0;
    localparam int CTRL_TX_IRQ_EN = 1;

    function automatic logic [31:0] pack_status(
        input logic       rx_nonempty,
        input logic       tx_notfull,
        input logic       tx_overrun,
        input logic [7:0] rx_count,
        input logic [7:0] tx_count
    );
        logic [31:0] word;
        word                           = '0;
        word[ST_RX_NONEMPTY]           = rx_nonempty;
        word[ST_TX_NOTFULL]            = tx_notfull;
        word[ST_TX_OVERRUN]            = tx_overrun;
        word[ST_RX_COUNT_LSB +: 8]     = rx_count;
        word[ST_TX_COUNT_LSB +: 8]     = tx_count;
        return word;
    endfunction

endpackage

// File: rtl/serial_mmio_fifo_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head; push is ignored when
// full and pop is ignored when empty, so callers may gate loosely.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/serial_mmio_fifo.sv
// Memory-mapped serial port with RX/TX FIFOs for the single-cycle MIPS core.
// Optional interrupt logic and CTRL register are built when SERIAL_IRQ_EN is defined.
module serial_mmio_fifo
    import serial_mmio_pkg::*;
#(
    parameter int          DATA_WIDTH = 8,
    parameter int          RX_DEPTH   = 16,
    parameter int          TX_DEPTH   = 16,
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF0000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           addr_in,
    input  logic [31:0]           writedata_in,
    input  logic                  re_in,
    input  logic                  we_in,
    output logic [31:0]           readdata_out,
    output logic                  hit_out,
    input  logic [DATA_WIDTH-1:0] serial_in,
    input  logic                  serial_valid_in,
    output logic                  serial_rden_out,
    output logic [DATA_WIDTH-1:0] serial_out,
    output logic                  serial_wren_out,
    input  logic                  serial_ready_in,
    output logic                  irq_out
);
    logic [3:0]                      reg_off;
    logic                            acc_rd, acc_wr;
    logic                            rx_push, rx_pop, rx_full, rx_empty;
    logic                            tx_push, tx_pop, tx_full, tx_empty;
    logic [DATA_WIDTH-1:0]           rx_head, tx_head;
    logic [$clog2(RX_DEPTH):0]       rx_count;
    logic [$clog2(TX_DEPTH):0]       tx_count;
    logic                            tx_overrun_q, tx_overrun_d;
    logic [31:0]                     rd_data;
    logic                            unused_bits;

    assign hit_out     = (addr_in[31:4] == BASE_ADDR[31:4]);
    assign reg_off     = {addr_in[3:2], 2'b00};
    assign acc_rd      = hit_out & re_in;
    assign acc_wr      = hit_out & we_in;
    assign unused_bits = ^{writedata_in, addr_in[1:0]};

    assign rx_push = serial_valid_in & ~rx_full;
    assign rx_pop  = acc_rd & (reg_off == OFF_DATA) & ~rx_empty;
    assign tx_push = acc_wr & (reg_off == OFF_DATA) & ~tx_full;
    assign tx_pop  = ~tx_empty & serial_ready_in;

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_push),
        .wdata (serial_in),
        .pop   (rx_pop),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (tx_push),
        .wdata (writedata_in[DATA_WIDTH-1:0]),
        .pop   (tx_pop),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    // Full is judged at the start of the cycle, so a same-cycle drain never rescues the store.
    always_comb begin
        tx_overrun_d = tx_overrun_q;
        if (acc_wr && reg_off == OFF_STATUS && writedata_in[ST_TX_OVERRUN])
            tx_overrun_d = 1'b0;
        if (acc_wr && reg_off == OFF_DATA && tx_full)
            tx_overrun_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) tx_overrun_q <= 1'b0;
        else        tx_overrun_q <= tx_overrun_d;
    end

`ifdef SERIAL_IRQ_EN
    logic [1:0] ctrl_q, ctrl_d;
    logic       irq_q, irq_d;

    always_comb begin
        ctrl_d = ctrl_q;
        if (acc_wr && reg_off == OFF_CTRL) ctrl_d = writedata_in[1:0];
        irq_d = (ctrl_q[CTRL_RX_IRQ_EN] & ~rx_empty) | (ctrl_q[CTRL_TX_IRQ_EN] & tx_empty);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctrl_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            irq_q  <= irq_d;
        end
    end

    assign irq_out = irq_q;
`else
    assign irq_out = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        if (acc_rd) begin
            case (reg_off)
                OFF_DATA:   if (!rx_empty) rd_data = 32'(rx_head);
                OFF_STATUS: rd_data = pack_status(~rx_empty, ~tx_full, tx_overrun_q,
                                                  8'(rx_count), 8'(tx_count));
`ifdef SERIAL_IRQ_EN
                OFF_CTRL:   rd_data = {30'b0, ctrl_q};
`endif
                default:    rd_data = '0;
            endcase
        end
    end

    // Reset level gates the outputs so nothing stale escapes while held in reset.
    assign readdata_out    = reset ? rd_data : '0;
    assign serial_rden_out = reset & rx_push;
    assign serial_wren_out = reset & ~tx_empty;
    assign serial_out      = (reset && !tx_empty) ? tx_head : '0;

endmodule

// File: tb/tb_serial_mmio_fifo.sv
// Directed self-checking bench for serial_mmio_fifo; one task per scenario.
module tb_serial_mmio_fifo;
    localparam logic [31:0] BASE = 32'hFFFF0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr_in = BASE;
    logic [31:0] writedata_in = '0;
    logic        re_in = 1'b0;
    logic        we_in = 1'b0;
    logic [31:0] readdata_out;
    logic        hit_out;
    logic [7:0]  serial_in = '0;
    logic        serial_valid_in = 1'b0;
    logic        serial_rden_out;
    logic [7:0]  serial_out;
    logic        serial_wren_out;
    logic        serial_ready_in = 1'b0;
    logic        irq_out;

    int tests_run = 0;
    int fails = 0;

    always #5 clock = ~clock;

    serial_mmio_fifo dut (
        .clock           (clock),
        .reset           (reset),
        .addr_in         (addr_in),
        .writedata_in    (writedata_in),
        .re_in           (re_in),
        .we_in           (we_in),
        .readdata_out    (readdata_out),
        .hit_out         (hit_out),
        .serial_in       (serial_in),
        .serial_valid_in (serial_valid_in),
        .serial_rden_out (serial_rden_out),
        .serial_out      (serial_out),
        .serial_wren_out (serial_wren_out),
        .serial_ready_in (serial_ready_in),
        .irq_out         (irq_out)
    );

    // Bus tasks start and end at posedge+1; data is sampled at the negedge.
    task automatic cpu_read(input logic [3:0] off, output logic [31:0] d);
        addr_in = BASE | 32'(off);
        re_in   = 1'b1;
        #4;
        d = readdata_out;
        @(posedge clock); #1;
        re_in = 1'b0;
    endtask

    task automatic cpu_write(input logic [3:0] off, input logic [31:0] d);
        addr_in      = BASE | 32'(off);
        writedata_in = d;
        we_in        = 1'b1;
        @(posedge clock); #1;
        we_in = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        addr_in = BASE | 32'h4;
        re_in = 1'b1;
        serial_valid_in = 1'b1;
        #2;
        tests_run++;
        if (readdata_out !== 32'h0 || serial_wren_out !== 1'b0 || serial_rden_out !== 1'b0
            || serial_out !== 8'h00 || irq_out !== 1'b0) begin
            fails++;
            $display("FAIL in_reset rd=%h wren=%b rden=%b out=%h irq=%b required 0", readdata_out,
                     serial_wren_out, serial_rden_out, serial_out, irq_out);
        end
        re_in = 1'b0;
        serial_valid_in = 1'b0;
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        @(posedge clock); #1;
        cpu_read(4'h4, d);
        tests_run++;
        if (d !== 32'h00000002) begin
            fails++; $display("FAIL reset_status got %h required 00000002", d);
        end
        tests_run++;
        if (irq_out !== 1'b0 || serial_wren_out !== 1'b0) begin
            fails++; $display("FAIL reset_outputs irq=%b wren=%b required 0", irq_out, serial_wren_out);
        end
        addr_in = BASE + 32'h10;
        #1;
        tests_run++;
        if (hit_out !== 1'b0) begin
            fails++; $display("FAIL hit_outside got %b required 0", hit_out);
        end
        addr_in = BASE + 32'hF;
        #1;
        tests_run++;
        if (hit_out !== 1'b1) begin
            fails++; $display("FAIL hit_inside got %b required 1", hit_out);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_rx_single();
        logic [31:0] d;
        serial_in = 8'h41;
        serial_valid_in = 1'b1;
        #4;
        tests_run++;
        if (serial_rden_out !== 1'b1) begin
            fails++; $display("FAIL rx_rden got %b required 1", serial_rden_out);
        end
        @(posedge clock); #1;
        serial_valid_in = 1'b0;
        cpu_read(4'h0, d);
        tests_run++;
        if (d !== 32'h00000041) begin
            fails++; $display("FAIL rx_data got %h required 00000041", d);
        end
        cpu_read(4'h4, d);
        tests_run++;
        if (d !== 32'h00000002) begin
            fails++; $display("FAIL rx_status_after_pop got %h required 00000002", d);
        end
        cpu_read(4'h0, d);
        tests_run++;
        if (d !== 32'h0) begin
            fails++; $display("FAIL rx_empty_read got %h required 00000000", d);
        end
    endtask

    task automatic test_tx_overrun();
        logic [31:0] d;
        serial_ready_in = 1'b0;
        for (int i = 0; i <= 16; i++) cpu_write(4'h0, 32'(i));
        cpu_read(4'h4, d);
        tests_run++;
        if (d !== 32'h00100004) begin
            fails++; $display("FAIL tx_full_status got %h required 00100004", d);
        end
        cpu_write(4'h4, 32'h4);
        cpu_read(4'h4, d);
        tests_run++;
        if (d !== 32'h00100000) begin
            fails++; $display("FAIL tx_overrun_clear got %h required 00100000", d);
        end
        serial_ready_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #4;
            tests_run++;
            if (serial_wren_out !== 1'b1 || serial_out !== 8'(i)) begin
                fails++;
                $display("FAIL tx_drain[%0d] wren=%b out=%h required 1/%h", i, serial_wren_out, serial_out, 8'(i));
            end
            @(posedge clock); #1;
        end
        repeat (3) begin
            #4;
            tests_run++;
            if (serial_wren_out !== 1'b0) begin
                fails++; $display("FAIL tx_drain_end wren=%b out=%h required 0", serial_wren_out, serial_out);
            end
            @(posedge clock); #1;
        end
        serial_ready_in = 1'b0;
    endtask

    task automatic test_rx_full();
        logic [31:0] d;
        serial_valid_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            serial_in = 8'h80 + 8'(i);
            #4;
            tests_run++;
            if (serial_rden_out !== 1'b1) begin
                fails++; $display("FAIL rx_fill_rden[%0d] got %b required 1", i, serial_rden_out);
            end
            @(posedge clock); #1;
        end
        serial_in = 8'h90;
        #4;
        tests_run++;
        if (serial_rden_out !== 1'b0) begin
            fails++; $display("FAIL rx_full_rden got %b required 0", serial_rden_out);
        end
        @(posedge clock); #1;
        cpu_read(4'h4, d);
        tests_run++;
        if (d !== 32'h00001003) begin
            fails++; $display("FAIL rx_full_status got %h required 00001003", d);
        end
        addr_in = BASE;
        re_in = 1'b1;
        #4;
        tests_run++;
        if (readdata_out !== 32'h80 || serial_rden_out !== 1'b0) begin
            fails++; $display("FAIL rx_full_pop rd=%h rden=%b required 00000080/0", readdata_out, serial_rden_out);
        end
        @(posedge clock); #1;
        re_in = 1'b0;
        #4;
        tests_run++;
        if (serial_rden_out !== 1'b1) begin
            fails++; $display("FAIL rx_refill_rden got %b required 1", serial_rden_out);
        end
        @(posedge clock); #1;
        serial_valid_in = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            cpu_read(4'h0, d);
            tests_run++;
            if (d !== 32'h80 + 32'(i)) begin
                fails++; $display("FAIL rx_drain[%0d] got %h required %h", i, d, 32'h80 + 32'(i));
            end
        end
        cpu_read(4'h4, d);
        tests_run++;
        if (d !== 32'h00000002) begin
            fails++; $display("FAIL rx_drained_status got %h required 00000002", d);
        end
    endtask

    task automatic test_tx_full_simul();
        logic [31:0] d;
        serial_ready_in = 1'b0;
        for (int i = 0; i < 16; i++) cpu_write(4'h0, 32'hA0 + 32'(i));
        serial_ready_in = 1'b1;
        cpu_write(4'h0, 32'hEE);
        serial_ready_in = 1'b0;
        cpu_read(4'h4, d);
        tests_run++;
        if (d !== 32'h000F0006) begin
            fails++; $display("FAIL tx_simul_status got %h required 000F0006", d);
        end
        serial_ready_in = 1'b1;
        for (int i = 1; i < 16; i++) begin
            #4;
            tests_run++;
            if (serial_wren_out !== 1'b1 || serial_out !== 8'hA0 + 8'(i)) begin
                fails++;
                $display("FAIL tx_simul_drain[%0d] wren=%b out=%h required 1/%h", i, serial_wren_out, serial_out, 8'hA0 + 8'(i));
            end
            @(posedge clock); #1;
        end
        #4;
        tests_run++;
        if (serial_wren_out !== 1'b0) begin
            fails++; $display("FAIL tx_simul_extra wren=%b out=%h required 0", serial_wren_out, serial_out);
        end
        @(posedge clock); #1;
        serial_ready_in = 1'b0;
        cpu_write(4'h4, 32'h4);
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        cpu_write(4'hC, 32'hFFFFFFFF);
        cpu_read(4'hC, d);
        tests_run++;
        if (d !== 32'h0) begin
            fails++; $display("FAIL offset_c got %h required 00000000", d);
        end
        cpu_read(4'h4, d);
        tests_run++;
        if (d !== 32'h00000002) begin
            fails++; $display("FAIL offset_c_side_effect got %h required 00000002", d);
        end
    endtask

    task automatic test_irq();
        logic [31:0] d;
`ifdef SERIAL_IRQ_EN
        cpu_write(4'h8, 32'h1);
        cpu_read(4'h8, d);
        tests_run++;
        if (d !== 32'h1) begin
            fails++; $display("FAIL ctrl_readback got %h required 00000001", d);
        end
        serial_in = 8'h55;
        serial_valid_in = 1'b1;
        @(posedge clock); #1;
        serial_valid_in = 1'b0;
        #4;
        tests_run++;
        if (irq_out !== 1'b0) begin
            fails++; $display("FAIL irq_lag got %b required 0", irq_out);
        end
        @(posedge clock); #5;
        tests_run++;
        if (irq_out !== 1'b1) begin
            fails++; $display("FAIL irq_assert got %b required 1", irq_out);
        end
        @(posedge clock); #1;
        cpu_read(4'h0, d);
        tests_run++;
        if (d !== 32'h55) begin
            fails++; $display("FAIL irq_data got %h required 00000055", d);
        end
        #4;
        tests_run++;
        if (irq_out !== 1'b1) begin
            fails++; $display("FAIL irq_hold got %b required 1", irq_out);
        end
        @(posedge clock); #5;
        tests_run++;
        if (irq_out !== 1'b0) begin
            fails++; $display("FAIL irq_deassert got %b required 0", irq_out);
        end
        @(posedge clock); #1;
        cpu_write(4'h8, 32'h0);
`else
        cpu_write(4'h8, 32'h3);
        cpu_read(4'h8, d);
        tests_run++;
        if (d !== 32'h0 || irq_out !== 1'b0) begin
            fails++; $display("FAIL ctrl_absent rd=%h irq=%b required 00000000/0", d, irq_out);
        end
`endif
    endtask

    task automatic test_reset_midflight();
        logic [31:0] d;
        serial_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) cpu_write(4'h0, 32'h30 + 32'(i));
        serial_valid_in = 1'b1;
        serial_in = 8'h77;
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if (serial_wren_out !== 1'b0 || serial_out !== 8'h00 || serial_rden_out !== 1'b0) begin
            fails++;
            $display("FAIL midreset_outputs wren=%b out=%h rden=%b required 0", serial_wren_out, serial_out, serial_rden_out);
        end
        serial_valid_in = 1'b0;
        @(posedge clock); #3 reset = 1'b1;
        @(posedge clock); #1;
        cpu_read(4'h4, d);
        tests_run++;
        if (d !== 32'h00000002 || serial_wren_out !== 1'b0) begin
            fails++; $display("FAIL midreset_status got %h wren=%b required 00000002/0", d, serial_wren_out);
        end
    endtask

    initial begin
        test_reset();
        test_rx_single();
        test_tx_overrun();
        test_rx_full();
        test_tx_full_simul();
        test_unmapped();
        test_irq();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
